async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
Write-domain pointer/flag controller of the async FIFO. It generates the binary write address and the write enable for the dual-port memory. It also generates the registered Gray-coded write pointer that crosses into the read domain through the bit synchronizer. FULL is computed by comparing the next write pointer against the read pointer, which arrives already synchronized into CLK (write) domain.

Parameters:
ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 6, fill level at or above which AFULL asserts; legal range 1..2**ADDR_WIDTH.

Ports:
CLK  input  1  write-domain clock
RST  input  1  reset, asynchronous, active-low
WR_INC  input  1  write request; one word per cycle while high
RD_PTR_SYNC  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into CLK domain
WR_EN  output  1  memory write strobe = WR_INC & ~FULL (combinational)
WR_ADDR  output  ADDR_WIDTH  memory write address = wr_bin[ADDR_WIDTH-1:0]
WR_PTR_GRAY  output  ADDR_WIDTH+1  registered Gray write pointer to the read-domain synchronizer
FULL  output  1  registered full flag
AFULL  output  1  registered almost-full flag

Behaviour:
- Reset (RST low, asynchronous): wr_bin=0, WR_PTR_GRAY=0, FULL=0, AFULL=0. WR_ADDR=0 and WR_EN=0 follow from these.
- Reset mid-operation: all state clears immediately, without waiting for a CLK edge. Data already written is abandoned. The read side must be reset in the same reset event.
- wr_bin_next = wr_bin + WR_EN. The addition is modulo 2**(ADDR_WIDTH+1) and wraps naturally.
- wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
- On each CLK rising edge: wr_bin <= wr_bin_next and WR_PTR_GRAY <= wr_gray_next.
- WR_PTR_GRAY must be driven directly by a flop, with no logic between the flop and the port. Between any two consecutive CLK edges it changes by at most one bit.
- Accept rule: on an edge where WR_INC=1 and FULL=0, the memory writes WR_ADDR and the pointer advances by 1.
- Write while full: WR_EN=0, no pointer change, no error flag raised, and the word is dropped. The upstream block must hold WR_INC until FULL=0.
- FULL <= (wr_gray_next == {~RD_PTR_SYNC[ADDR_WIDTH:ADDR_WIDTH-1], RD_PTR_SYNC[ADDR_WIDTH-2:0]}).
  - FULL asserts on the same edge that accepts the last free slot.
  - FULL deasserts one CLK edge after RD_PTR_SYNC advances.
  - For ADDR_WIDTH=1, the low-field slice is empty and the compare uses the inverted 2 MSBs only.
- Fill level: rd_bin = gray2bin(RD_PTR_SYNC), computed as an XOR prefix from the MSB. level_next = wr_bin_next - rd_bin, ADDR_WIDTH+1 bits, modulo.
- AFULL <= (level_next >= AFULL_THRESH).
- FULL and AFULL are pessimistic: the synchronizer delays RD_PTR_SYNC, so both flags may stay asserted up to NUM_STAGES+1 cycles after the reader frees space. They never under-report occupancy.
- Simultaneous write and read-pointer change on one edge: both are folded into level_next and the FULL compare. No special priority is applied.
- Pointer wrap (wr_bin from 2**(ADDR_WIDTH+1)-1 to 0): the Gray code wraps with a single-bit change (MSB only), and FULL/level arithmetic stays correct.

Optional Feature:
- Macro: ASYNC_FIFO_WR_LEVEL_EN.
- Defined: adds output port WR_LEVEL [ADDR_WIDTH:0], a registered copy of level_next that updates on the same edge as FULL. Reset value is 0, and it reaches 2**ADDR_WIDTH when FULL=1.
- Not defined: the port is absent and no level register exists. level_next remains internal logic for AFULL only, and all other behaviour is identical.

Test Plan:
All scenarios use ADDR_WIDTH=3 and AFULL_THRESH=6, with RD_PTR_SYNC held at 0 unless stated.

1. Fill to full: drive WR_INC=1 for 8 cycles.
   - WR_ADDR steps 0..7.
   - WR_PTR_GRAY steps 0,1,3,2,6,7,5,4, then 0xC.
   - AFULL=1 after the 6th write; FULL=1 after the 8th write.
   - 9th cycle: WR_EN=0 and WR_PTR_GRAY holds at 0xC.
2. Release full: from full, set RD_PTR_SYNC=1 (Gray of 1) -> FULL=0 after the next edge, and the next WR_INC write lands at WR_ADDR=0.
3. Wrap: keep the reader tracking the writer (RD_PTR_SYNC = writer Gray delayed by 2 cycles) for 20 writes.
   - wr_bin wraps 15->0 and WR_PTR_GRAY goes 0x8->0x0.
   - Exactly one bit toggles per accepted write throughout.
   - FULL never asserts.
4. Asynchronous reset: assert RST low mid-burst between clock edges (wr_bin=5) -> WR_PTR_GRAY=0, FULL=0, AFULL=0 immediately. After RST is released, the first write goes to WR_ADDR=0.
5. Simultaneous write and read-pointer change: at level 7, write while RD_PTR_SYNC advances by 1 -> FULL stays 0, AFULL stays 1. With ASYNC_FIFO_WR_LEVEL_EN defined, WR_LEVEL stays 7.
6. Level feature: with ASYNC_FIFO_WR_LEVEL_EN defined, 3 writes give WR_LEVEL=3 and 8 writes give WR_LEVEL=8. With the macro undefined, the bench elaborates with no WR_LEVEL port.

Source files
------------

// File: rtl/async_fifo_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl_if
//
// Purpose:
//   Bundles the write-side handshake and pointer signals of the async FIFO
//   write controller. The clock and reset stay outside as plain ports.
//
// Signals:
//   WR_INC       write request from the upstream producer
//   RD_PTR_SYNC  Gray read pointer, already synchronized into the write domain
//   WR_EN        memory write strobe
//   WR_ADDR      memory write address
//   WR_PTR_GRAY  registered Gray write pointer toward the read-domain synchronizer
//   FULL         registered full flag
//   AFULL        registered almost-full flag
//   WR_LEVEL     registered fill level (only when ASYNC_FIFO_WR_LEVEL_EN is defined)
//
// Modports:
//   master  the write controller (drives strobe, address, pointer and flags)
//   slave   the surrounding logic (drives request and synchronized read pointer)
// -----------------------------------------------------------------------------
interface async_fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  WR_INC;
   logic [ADDR_WIDTH:0]   RD_PTR_SYNC;
   logic                  WR_EN;
   logic [ADDR_WIDTH-1:0] WR_ADDR;
   logic [ADDR_WIDTH:0]   WR_PTR_GRAY;
   logic                  FULL;
   logic                  AFULL;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
   logic [ADDR_WIDTH:0]   WR_LEVEL;

   modport master (
      input  WR_INC,
      input  RD_PTR_SYNC,
      output WR_EN,
      output WR_ADDR,
      output WR_PTR_GRAY,
      output FULL,
      output AFULL,
      output WR_LEVEL
   );

   modport slave (
      output WR_INC,
      output RD_PTR_SYNC,
      input  WR_EN,
      input  WR_ADDR,
      input  WR_PTR_GRAY,
      input  FULL,
      input  AFULL,
      input  WR_LEVEL
   );
`else
   modport master (
      input  WR_INC,
      input  RD_PTR_SYNC,
      output WR_EN,
      output WR_ADDR,
      output WR_PTR_GRAY,
      output FULL,
      output AFULL
   );

   modport slave (
      output WR_INC,
      output RD_PTR_SYNC,
      input  WR_EN,
      input  WR_ADDR,
      input  WR_PTR_GRAY,
      input  FULL,
      input  AFULL
   );
`endif
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
//
// Purpose:
//   Write-domain pointer and flag controller of the async FIFO. Keeps the
//   binary write pointer, produces the memory write strobe/address, the
//   registered Gray write pointer for the read-domain synchronizer, and the
//   registered FULL / AFULL flags derived from the synchronized read pointer.
//
// Parameters:
//   ADDR_WIDTH    memory address width; depth = 2**ADDR_WIDTH, pointers are
//                 ADDR_WIDTH+1 bits wide
//   AFULL_THRESH  fill level at or above which AFULL asserts (1..2**ADDR_WIDTH)
//
// Ports:
//   CLK   write-domain clock
//   RST   asynchronous, active-low reset
//   bus   async_fifo_wr_ctrl_if.master (WR_INC, RD_PTR_SYNC in; WR_EN,
//         WR_ADDR, WR_PTR_GRAY, FULL, AFULL [, WR_LEVEL] out)
//
// Build option:
//   ASYNC_FIFO_WR_LEVEL_EN  when defined, adds the registered WR_LEVEL output
//                           (a copy of the next fill level, updated with FULL).
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   async_fifo_wr_ctrl_if.master  bus
);

   localparam int              PW        = ADDR_WIDTH + 1;
   localparam logic [PW-1:0]   LP_THRESH = PW'(AFULL_THRESH);

   // Elaboration-time parameter sanity check.
   generate
      if (ADDR_WIDTH < 1) begin : g_bad_aw
         $error("async_fifo_wr_ctrl: ADDR_WIDTH must be >= 1");
      end
      if (AFULL_THRESH < 1 || AFULL_THRESH > (2 ** ADDR_WIDTH)) begin : g_bad_th
         $error("async_fifo_wr_ctrl: AFULL_THRESH out of range 1..2**ADDR_WIDTH");
      end
   endgenerate

   // State
   logic [PW-1:0] r_wr_bin;
   logic [PW-1:0] r_wr_gray;
   logic          r_full;
   logic          r_afull;

   // Next-state / combinational
   logic          w_wr_en;
   logic [PW-1:0] w_wr_bin_next;
   logic [PW-1:0] w_wr_gray_next;
   logic [PW-1:0] w_rd_bin;
   logic [PW-1:0] w_full_cmp;
   logic [PW-1:0] w_level_next;
   logic          w_full_next;
   logic          w_afull_next;

   // A request is only honoured while not full; a write attempted while full
   // is silently dropped and the pointer holds.
   assign w_wr_en        = bus.WR_INC & ~r_full;
   assign w_wr_bin_next  = r_wr_bin + {{(PW-1){1'b0}}, w_wr_en};
   assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);

   // Gray-to-binary of the synchronized read pointer: each binary bit is the
   // XOR of all Gray bits from the MSB down to that position.
   assign w_rd_bin[PW-1] = bus.RD_PTR_SYNC[PW-1];
   generate
      for (genvar gi = PW - 2; gi >= 0; gi--) begin : g_gray2bin
         assign w_rd_bin[gi] = w_rd_bin[gi+1] ^ bus.RD_PTR_SYNC[gi];
      end
   endgenerate

   // Full pattern in Gray space: the writer is exactly one lap ahead when its
   // two MSBs are the inverse of the reader's and the remaining bits match.
   assign w_full_cmp[PW-1:PW-2] = ~bus.RD_PTR_SYNC[PW-1:PW-2];
   generate
      if (ADDR_WIDTH >= 2) begin : g_full_low
         assign w_full_cmp[PW-3:0] = bus.RD_PTR_SYNC[PW-3:0];
      end
   endgenerate

   assign w_full_next = (w_wr_gray_next == w_full_cmp);

   // Modulo subtraction stays correct across pointer wrap because the
   // occupancy never exceeds the depth.
   assign w_level_next = w_wr_bin_next - w_rd_bin;
   assign w_afull_next = (w_level_next >= LP_THRESH);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_bin  <= '0;
         r_wr_gray <= '0;
         r_full    <= 1'b0;
         r_afull   <= 1'b0;
      end else begin
         r_wr_bin  <= w_wr_bin_next;
         r_wr_gray <= w_wr_gray_next;
         r_full    <= w_full_next;
         r_afull   <= w_afull_next;
      end
   end

`ifdef ASYNC_FIFO_WR_LEVEL_EN
   logic [PW-1:0] r_wr_level;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_level <= '0;
      end else begin
         r_wr_level <= w_level_next;
      end
   end

   assign bus.WR_LEVEL = r_wr_level;
`endif

   // WR_PTR_GRAY comes straight from its flop so the synchronizer only ever
   // sees single-bit transitions.
   assign bus.WR_EN       = w_wr_en;
   assign bus.WR_ADDR     = r_wr_bin[ADDR_WIDTH-1:0];
   assign bus.WR_PTR_GRAY = r_wr_gray;
   assign bus.FULL        = r_full;
   assign bus.AFULL       = r_afull;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_ctrl
//
// Self-checking bench for async_fifo_wr_ctrl with ADDR_WIDTH=3, AFULL_THRESH=6.
// A constant vector table covers fill-to-full and full release; hand-written
// sequences cover asynchronous reset, pointer wrap and simultaneous
// write/read-pointer change; a random phase is checked against an occupancy
// model that counts accepted writes and reader progress as plain integers.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_ctrl;

   localparam int AW    = 3;
   localparam int TH    = 6;
   localparam int DEPTH = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   async_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   async_fifo_wr_ctrl #(
      .ADDR_WIDTH   (AW),
      .AFULL_THRESH (TH)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Occupancy model: totals of accepted writes and of reads seen via RD_PTR_SYNC.
   int m_wr   = 0;
   int m_rd   = 0;
   bit m_full = 1'b0;

   typedef struct {
      logic       inc;
      logic [3:0] rd_gray;
      logic       exp_en;
      logic [2:0] exp_addr;
      logic [3:0] exp_gray;
      logic       exp_full;
      logic       exp_afull;
      int         exp_level;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_wr   = 0;
      m_rd   = 0;
      m_full = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      bus.WR_INC      = 1'b0;
      bus.RD_PTR_SYNC = '0;
      RST             = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      model_reset();
   endtask

   // One cycle: apply inputs at the falling edge, check the combinational
   // strobe/address, then check registered outputs just after the rising edge.
   task automatic step(input bit inc, input int rd_cnt);
      bit exp_en;
      int occ;
      @(negedge CLK);
      bus.WR_INC      = inc;
      bus.RD_PTR_SYNC = gray(rd_cnt);
      m_rd            = rd_cnt;
      exp_en          = inc && !m_full;
      #1;
      chk("wr_en", int'(bus.WR_EN), int'(exp_en));
      chk("wr_addr", int'(bus.WR_ADDR), m_wr % DEPTH);
      @(posedge CLK);
      #1;
      if (exp_en) m_wr++;
      occ    = m_wr - m_rd;
      m_full = (occ == DEPTH);
      $display("[TB] step inc=%0b rd=%0d wr=%0d occ=%0d gray=%0h full=%0b afull=%0b",
               inc, rd_cnt, m_wr, occ, bus.WR_PTR_GRAY, bus.FULL, bus.AFULL);
      chk("wr_ptr_gray", int'(bus.WR_PTR_GRAY), int'(gray(m_wr)));
      chk("full", int'(bus.FULL), int'(m_full));
      chk("afull", int'(bus.AFULL), int'(occ >= TH));
`ifdef ASYNC_FIFO_WR_LEVEL_EN
      chk("wr_level", int'(bus.WR_LEVEL), occ);
`endif
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [3:0] prev_gray;
      int         wr_hist [20];
      bit         wrap_seen;
      int         rd_new;

      // Fill to full (rows 0..8), then release full and refill (rows 9..11).
      //             inc   rd     en    addr  gray   full  afull level
      tbl[0]  = '{1'b1, 4'h0, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0, 1};
      tbl[1]  = '{1'b1, 4'h0, 1'b1, 3'd1, 4'h3, 1'b0, 1'b0, 2};
      tbl[2]  = '{1'b1, 4'h0, 1'b1, 3'd2, 4'h2, 1'b0, 1'b0, 3};
      tbl[3]  = '{1'b1, 4'h0, 1'b1, 3'd3, 4'h6, 1'b0, 1'b0, 4};
      tbl[4]  = '{1'b1, 4'h0, 1'b1, 3'd4, 4'h7, 1'b0, 1'b0, 5};
      tbl[5]  = '{1'b1, 4'h0, 1'b1, 3'd5, 4'h5, 1'b0, 1'b1, 6};
      tbl[6]  = '{1'b1, 4'h0, 1'b1, 3'd6, 4'h4, 1'b0, 1'b1, 7};
      tbl[7]  = '{1'b1, 4'h0, 1'b1, 3'd7, 4'hC, 1'b1, 1'b1, 8};
      tbl[8]  = '{1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 8};
      tbl[9]  = '{1'b0, 4'h1, 1'b0, 3'd0, 4'hC, 1'b0, 1'b1, 7};
      tbl[10] = '{1'b1, 4'h1, 1'b1, 3'd0, 4'hD, 1'b1, 1'b1, 8};
      tbl[11] = '{1'b1, 4'h1, 1'b0, 3'd1, 4'hD, 1'b1, 1'b1, 8};

      // Reset state, checked while RST is still low and before any edge matters.
      bus.WR_INC      = 1'b0;
      bus.RD_PTR_SYNC = '0;
      #12;
      chk("rst_gray", int'(bus.WR_PTR_GRAY), 0);
      chk("rst_full", int'(bus.FULL), 0);
      chk("rst_afull", int'(bus.AFULL), 0);
      chk("rst_addr", int'(bus.WR_ADDR), 0);
      chk("rst_en", int'(bus.WR_EN), 0);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
      chk("rst_level", int'(bus.WR_LEVEL), 0);
`endif
      @(negedge CLK);
      RST = 1'b1;

      // Table-driven fill/full/release.
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         bus.WR_INC      = tbl[i].inc;
         bus.RD_PTR_SYNC = tbl[i].rd_gray;
         #1;
         chk("tbl_wr_en", int'(bus.WR_EN), int'(tbl[i].exp_en));
         chk("tbl_wr_addr", int'(bus.WR_ADDR), int'(tbl[i].exp_addr));
         @(posedge CLK);
         #1;
         $display("[TB] vec %0d inc=%0b rd=%0h gray=%0h full=%0b afull=%0b",
                  i, tbl[i].inc, tbl[i].rd_gray, bus.WR_PTR_GRAY, bus.FULL, bus.AFULL);
         chk("tbl_gray", int'(bus.WR_PTR_GRAY), int'(tbl[i].exp_gray));
         chk("tbl_full", int'(bus.FULL), int'(tbl[i].exp_full));
         chk("tbl_afull", int'(bus.AFULL), int'(tbl[i].exp_afull));
`ifdef ASYNC_FIFO_WR_LEVEL_EN
         chk("tbl_level", int'(bus.WR_LEVEL), tbl[i].exp_level);
`endif
      end

      // Asynchronous reset mid-burst, between clock edges.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 0);
      chk("pre_arst_gray", int'(bus.WR_PTR_GRAY), int'(gray(5)));
      @(negedge CLK);
      bus.WR_INC = 1'b0;
      #2;
      RST = 1'b0;
      #1;
      $display("[TB] async reset asserted mid-cycle gray=%0h full=%0b afull=%0b",
               bus.WR_PTR_GRAY, bus.FULL, bus.AFULL);
      chk("arst_gray", int'(bus.WR_PTR_GRAY), 0);
      chk("arst_full", int'(bus.FULL), 0);
      chk("arst_afull", int'(bus.AFULL), 0);
      chk("arst_addr", int'(bus.WR_ADDR), 0);
      chk("arst_en", int'(bus.WR_EN), 0);
      @(negedge CLK);
      RST = 1'b1;
      model_reset();
      step(1'b1, 0);

      // Wrap: reader follows the writer two cycles late for 20 writes.
      do_reset();
      wrap_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         wr_hist[k] = m_wr;
         prev_gray  = bus.WR_PTR_GRAY;
         step(1'b1, (k >= 2) ? wr_hist[k-2] : 0);
         chk("wrap_one_bit", $countones(prev_gray ^ bus.WR_PTR_GRAY), 1);
         chk("wrap_no_full", int'(bus.FULL), 0);
         if (prev_gray == 4'h8 && bus.WR_PTR_GRAY == 4'h0) wrap_seen = 1'b1;
      end
      chk("wrap_seen", int'(wrap_seen), 1);

      // Simultaneous write and read-pointer advance at level 7.
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 0);
      step(1'b1, 1);
      chk("simul_full", int'(bus.FULL), 0);
      chk("simul_afull", int'(bus.AFULL), 1);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
      chk("simul_level", int'(bus.WR_LEVEL), 7);
`endif

      // Random traffic against the occupancy model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rd_new = m_rd;
         if ($urandom_range(0, 2) == 0)
            rd_new = m_rd + int'($urandom_range(0, m_wr - m_rd));
         step($urandom_range(0, 3) != 0, rd_new);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
